rv64i_alu: RTL and testbench
============================

// Module: rv64i_alu
// PURPOSE
//  RV64I integer execute-stage ALU: one operation selected by RISC-V funct3/funct7 on two operands.
//  Covers ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND.
//  Registered output stage, one-cycle latency; feeds the writeback mux and the branch-compare logic (zero flag).
// PARAMETERS
//  XLEN  64  operand/result width; shift amount width SHW = $clog2(XLEN) (6 at default)
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst        in   1     reset, synchronous, active-high
//  in_valid   in   1     operands/opcode valid this cycle
//  a          in   XLEN  operand A (rs1)
//  b          in   XLEN  operand B (rs2 or immediate)
//  funct3     in   3     operation select
//  funct7     in   7     modifier; only bit 5 is decoded
//  is_word    in   1     32-bit W-op select; present only with ALU_WORD_OPS_EN
//  result     out  XLEN  registered result
//  zero       out  1     registered, 1 when result == 0
//  out_valid  out  1     result/zero valid; in_valid delayed one cycle
// BEHAVIOUR
//  - Reset (rst=1 at posedge): result=0, zero=1, out_valid=0. Reset overrides in_valid; reset mid-operation discards the in-flight op.
//  - Latency 1: op presented with in_valid=1 at edge N appears on result/zero at edge N+1 with out_valid=1.
//  - in_valid=0: result and zero hold their previous values, out_valid=0. No backpressure.
//  - Decode (f7b = funct7[5]):
//    000: f7b=0 ADD a+b; f7b=1 SUB a-b. Modulo 2^XLEN, overflow ignored.
//    001: SLL a << b[SHW-1:0]
//    010: SLT: 1 if $signed(a) < $signed(b), else 0 (zero-extended to XLEN)
//    011: SLTU: 1 if a < b unsigned, else 0
//    100: XOR   110: OR   111: AND
//    101: f7b=0 SRL logical; f7b=1 SRA arithmetic (sign fill). Shift amount b[SHW-1:0].
//  - Upper bits of b above SHW are ignored for shifts.
//  - funct7 bits other than 5 are ignored; f7b is ignored for funct3 other than 000/101.
//  - zero is computed from the same next-result value and registered with it (never lags result).
//  - All 8 funct3 codes are legal; no illegal-op output.
// CONFIGURATION
//  - Macro ALU_WORD_OPS_EN defined: is_word port exists.
//    is_word=1 with funct3 000/001/101 gives ADDW/SUBW/SLLW/SRLW/SRAW:
//    operate on a[31:0]/b[31:0], shift amount b[4:0], SRAW sign source a[31], 32-bit result sign-extended from bit 31 to XLEN.
//    is_word=1 with any other funct3 behaves as the normal XLEN-wide op.
//  - Macro undefined: no is_word port; only XLEN-wide ops. Requires XLEN=64 when defined.
// STRUCTURE
//  - Package rv64i_alu_pkg: funct3 localparams (F3_ADD=000, F3_SLL=001, F3_SLT=010, F3_SLTU=011,
//    F3_XOR=100, F3_SRL=101, F3_OR=110, F3_AND=111), F7B_ALT index (5), default XLEN.
//  - One combinational sub-module rv64i_alu_comb (opcode decode + datapath -> next_result).
//  - Top: output registers, zero flag, valid pipe.
// TESTING
//  1. ADD a=10,b=20,f3=000,f7=00 -> result=30 (0x1E), zero=0 next cycle. SUB a=30,b=10,f7=0x20 -> 20. SUB a=b=7 -> 0, zero=1.
//  2. a=FF00FF00FF00FF00, b=0F0F0F0F0F0F0F0F:
//     AND -> 0F000F000F000F00; OR -> FF0FFF0FFF0FFF0F; XOR -> F00FF00FF00FF00F.
//  3. SLL 1 by 8 -> 0x100. SRL 8000000000000000 by 4 -> 0800000000000000.
//     SRA F000000000000000 by 4 -> FF00000000000000. b=0x48 shifts by 8 (b[5:0] only).
//  4. SLT -5<3 -> 1; SLT 5<-3 -> 0, zero=1. SLTU FFFFFFFFFFFFFFFF<1 -> 0; SLTU 1<FFFFFFFFFFFFFFFF -> 1.
//  5. Valid/reset: in_valid=0 cycle -> result holds, out_valid=0. rst=1 with in_valid=1 -> result=0, zero=1, out_valid=0.
//  6. ALU_WORD_OPS_EN: ADDW 7FFFFFFF+1 -> FFFFFFFF80000000; SRAW 80000000 by 4 -> FFFFFFFFF8000000.

Source files
------------

// File: rtl/rv64i_alu_pkg.sv
// Shared constants for the RV64I execute-stage ALU: funct3 op codes,
// the decoded funct7 bit index and the default datapath width.
// Optional feature macro: ALU_WORD_OPS_EN (32-bit W-op support).
package rv64i_alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 bit that selects SUB over ADD and SRA over SRL
  localparam int F7B_ALT = 5;

endpackage

// File: rtl/rv64i_alu_if.sv
// Operand/result bundle of the RV64I ALU.
// Optional feature macro: ALU_WORD_OPS_EN adds the is_word select.
// Handshake: in_valid qualifies a/b/funct3/funct7(/is_word) in the cycle it
// is high; out_valid is in_valid delayed by one cycle and qualifies
// result/zero. There is no ready: the ALU accepts one op every cycle.
interface rv64i_alu_if #(
  parameter int XLEN = rv64i_alu_pkg::XLEN_DEFAULT
);
  logic            in_valid;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
`ifdef ALU_WORD_OPS_EN
  logic            is_word;
`endif
  logic [XLEN-1:0] result;
  logic            zero;
  logic            out_valid;

`ifdef ALU_WORD_OPS_EN
  modport master (output in_valid, a, b, funct3, funct7, is_word,
                  input  result, zero, out_valid);
  modport slave  (input  in_valid, a, b, funct3, funct7, is_word,
                  output result, zero, out_valid);
`else
  modport master (output in_valid, a, b, funct3, funct7,
                  input  result, zero, out_valid);
  modport slave  (input  in_valid, a, b, funct3, funct7,
                  output result, zero, out_valid);
`endif
endinterface

// File: rtl/rv64i_alu_comb.sv
// Combinational opcode decode and datapath producing the next ALU result.
// Optional feature macro: ALU_WORD_OPS_EN (ADDW/SUBW/SLLW/SRLW/SRAW when
// is_word=1; only meaningful with XLEN=64).
module rv64i_alu_comb
  import rv64i_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            f7b,
`ifdef ALU_WORD_OPS_EN
  input  logic            is_word,
`endif
  output logic [XLEN-1:0] next_result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] full_res;

  assign shamt = b[SHW-1:0];

  // Full-width operation select; f7b matters only for add/sub and right shifts
  always_comb begin
    full_res = '0;
    case (funct3)
      F3_ADD:  full_res = f7b ? (a - b) : (a + b);
      F3_SLL:  full_res = a << shamt;
      F3_SLT:  full_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      F3_SLTU: full_res = {{(XLEN-1){1'b0}}, (a < b)};
      F3_XOR:  full_res = a ^ b;
      F3_SRL:  full_res = f7b ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
      F3_OR:   full_res = a | b;
      F3_AND:  full_res = a & b;
      default: full_res = '0;
    endcase
  end

`ifdef ALU_WORD_OPS_EN
  logic [31:0] w_res;
  logic        w_op;

  // 32-bit W-op datapath on the low operand halves, sign-extended afterwards
  always_comb begin
    w_res = '0;
    w_op  = 1'b0;
    case (funct3)
      F3_ADD: begin
        w_op  = 1'b1;
        w_res = f7b ? (a[31:0] - b[31:0]) : (a[31:0] + b[31:0]);
      end
      F3_SLL: begin
        w_op  = 1'b1;
        w_res = a[31:0] << b[4:0];
      end
      F3_SRL: begin
        w_op  = 1'b1;
        w_res = f7b ? 32'($signed(a[31:0]) >>> b[4:0]) : (a[31:0] >> b[4:0]);
      end
      default: begin
        w_op  = 1'b0;
        w_res = '0;
      end
    endcase
  end

  // W-ops override only for add/sub/shift codes; other codes stay full width
  always_comb begin
    next_result = full_res;
    if (is_word && w_op) next_result = {{(XLEN-32){w_res[31]}}, w_res};
  end
`else
  assign next_result = full_res;
`endif

endmodule

// File: rtl/rv64i_alu.sv
// RV64I execute-stage ALU top: registered result, zero flag and valid pipe
// around the combinational datapath. One-cycle latency, no backpressure.
// Optional feature macro: ALU_WORD_OPS_EN (requires XLEN=64).
module rv64i_alu
  import rv64i_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  rv64i_alu_if.slave bus
);

  logic [XLEN-1:0] next_result;
  logic            unused_funct7;

  // Only funct7[5] is decoded; the rest of the field is deliberately dropped
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  rv64i_alu_comb #(.XLEN(XLEN)) u_comb (
    .a           (bus.a),
    .b           (bus.b),
    .funct3      (bus.funct3),
    .f7b         (bus.funct7[F7B_ALT]),
`ifdef ALU_WORD_OPS_EN
    .is_word     (bus.is_word),
`endif
    .next_result (next_result)
  );

  // Output stage: capture result and its zero flag together on a valid op
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.zero      <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result <= next_result;
        bus.zero   <= (next_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_rv64i_alu.sv
// Self-checking bench for rv64i_alu: directed vectors then random ops
// against a behavioural reference model.
// Optional feature macro: ALU_WORD_OPS_EN enables W-op stimulus.
module tb_rv64i_alu;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] last_exp;

  rv64i_alu_if #(.XLEN(64)) alu_if ();

  rv64i_alu #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (alu_if)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the ISA rules
  function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic w);
    int unsigned sh;
    logic        alt;
    logic [31:0] r32;
    logic [63:0] r;
    alt = f7[5];
    sh  = int'(b % 64);
    r   = 64'd0;
    if (w && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) begin
      sh = int'(b % 32);
      if (f3 == 3'd0)      r32 = alt ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
      else if (f3 == 3'd1) r32 = a[31:0] << sh;
      else begin
        r32 = a[31:0] >> sh;
        if (alt && a[31]) r32 = r32 | ~(32'hFFFF_FFFF >> sh);
      end
      return {{32{r32[31]}}, r32};
    end
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: begin
        if (a[63] != b[63]) r = a[63] ? 64'd1 : 64'd0;
        else                r = (a < b) ? 64'd1 : 64'd0;
      end
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> sh;
        if (alt && a[63]) r = r | ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // scoreboard: single comparison point
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver: present one op, check it one edge later
  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic [2:0] f3, input logic [6:0] f7, input logic w);
    logic [63:0] exp;
    exp = ref_alu(ta, tb_v, f3, f7, w);
    alu_if.in_valid = 1'b1;
    alu_if.a        = ta;
    alu_if.b        = tb_v;
    alu_if.funct3   = f3;
    alu_if.funct7   = f7;
`ifdef ALU_WORD_OPS_EN
    alu_if.is_word  = w;
`endif
    @(posedge clk);
    #1;
    chk({tag, ".result"}, alu_if.result, exp);
    chk({tag, ".zero"}, {63'd0, alu_if.zero}, {63'd0, exp == 64'd0});
    chk({tag, ".valid"}, {63'd0, alu_if.out_valid}, 64'd1);
    last_exp = exp;
  endtask

  // driver: idle cycle with junk on the operand bus
  task automatic run_idle(input string tag);
    alu_if.in_valid = 1'b0;
    alu_if.a        = {$urandom(), $urandom()};
    alu_if.b        = {$urandom(), $urandom()};
    alu_if.funct3   = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    chk({tag, ".hold"}, alu_if.result, last_exp);
    chk({tag, ".zero"}, {63'd0, alu_if.zero}, {63'd0, last_exp == 64'd0});
    chk({tag, ".valid"}, {63'd0, alu_if.out_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rw;
    checks = 0;
    errors = 0;
    last_exp = 64'd0;
    rst = 1'b1;
    alu_if.in_valid = 1'b0;
    alu_if.a = '0;
    alu_if.b = '0;
    alu_if.funct3 = '0;
    alu_if.funct7 = '0;
`ifdef ALU_WORD_OPS_EN
    alu_if.is_word = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset.result", alu_if.result, 64'd0);
    chk("reset.zero", {63'd0, alu_if.zero}, 64'd1);
    chk("reset.valid", {63'd0, alu_if.out_valid}, 64'd0);
    rst = 1'b0;

    // add/sub
    run_op("add", 64'd10, 64'd20, 3'b000, 7'h00, 1'b0);
    chk("add.const", alu_if.result, 64'h1E);
    run_op("sub", 64'd30, 64'd10, 3'b000, 7'h20, 1'b0);
    chk("sub.const", alu_if.result, 64'd20);
    run_op("sub_eq", 64'd7, 64'd7, 3'b000, 7'h20, 1'b0);
    chk("sub_eq.zero", {63'd0, alu_if.zero}, 64'd1);

    // logic ops
    run_op("and", 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 3'b111, 7'h00, 1'b0);
    chk("and.const", alu_if.result, 64'h0F000F000F000F00);
    run_op("or", 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 3'b110, 7'h20, 1'b0);
    chk("or.const", alu_if.result, 64'hFF0FFF0FFF0FFF0F);
    run_op("xor", 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 3'b100, 7'h00, 1'b0);
    chk("xor.const", alu_if.result, 64'hF00FF00FF00FF00F);

    // shifts
    run_op("sll", 64'd1, 64'd8, 3'b001, 7'h00, 1'b0);
    chk("sll.const", alu_if.result, 64'h100);
    run_op("srl", 64'h8000000000000000, 64'd4, 3'b101, 7'h00, 1'b0);
    chk("srl.const", alu_if.result, 64'h0800000000000000);
    run_op("sra", 64'hF000000000000000, 64'd4, 3'b101, 7'h20, 1'b0);
    chk("sra.const", alu_if.result, 64'hFF00000000000000);
    run_op("sll_mask", 64'd1, 64'h48, 3'b001, 7'h00, 1'b0);
    chk("sll_mask.const", alu_if.result, 64'h100);

    // compares
    run_op("slt_neg", -64'sd5, 64'd3, 3'b010, 7'h00, 1'b0);
    chk("slt_neg.const", alu_if.result, 64'd1);
    run_op("slt_pos", 64'd5, -64'sd3, 3'b010, 7'h00, 1'b0);
    chk("slt_pos.zero", {63'd0, alu_if.zero}, 64'd1);
    run_op("sltu_max", 64'hFFFFFFFFFFFFFFFF, 64'd1, 3'b011, 7'h00, 1'b0);
    chk("sltu_max.const", alu_if.result, 64'd0);
    run_op("sltu_one", 64'd1, 64'hFFFFFFFFFFFFFFFF, 3'b011, 7'h00, 1'b0);
    chk("sltu_one.const", alu_if.result, 64'd1);

    // valid / reset behaviour
    run_idle("idle");
    alu_if.in_valid = 1'b1;
    alu_if.a = 64'd3;
    alu_if.b = 64'd4;
    alu_if.funct3 = 3'b000;
    alu_if.funct7 = 7'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_op.result", alu_if.result, 64'd0);
    chk("rst_op.zero", {63'd0, alu_if.zero}, 64'd1);
    chk("rst_op.valid", {63'd0, alu_if.out_valid}, 64'd0);
    last_exp = 64'd0;
    run_idle("post_rst");

`ifdef ALU_WORD_OPS_EN
    run_op("addw", 64'h7FFFFFFF, 64'd1, 3'b000, 7'h00, 1'b1);
    chk("addw.const", alu_if.result, 64'hFFFFFFFF80000000);
    run_op("sraw", 64'h80000000, 64'd4, 3'b101, 7'h20, 1'b1);
    chk("sraw.const", alu_if.result, 64'hFFFFFFFFF8000000);
    run_op("xor_w", 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 3'b100, 7'h00, 1'b1);
    chk("xor_w.const", alu_if.result, 64'hF00FF00FF00FF00F);
`endif

    // random ops, with occasional equal or small operands and idle cycles
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = 64'($urandom_range(0, 15));
      rw = 1'b0;
`ifdef ALU_WORD_OPS_EN
      rw = 1'($urandom_range(0, 1));
`endif
      run_op("rand", ra, rb, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), rw);
      if ($urandom_range(0, 9) == 0) run_idle("rand_idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
